// File: rtl/darkaxi_arb_if.sv
// AXI4 bus bundle between darkaxi_arb (Master) and the memory-side slave (Slave).
interface AXI_BUS #(
  parameter int AW = 29,
  parameter int DW = 64,
  parameter int IW = 4
);
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [IW-1:0]   arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic [3:0]      arqos;
  logic            arvalid;
  logic            arready;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport Master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport Slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/darkaxi_arb.sv
// Round-robin fetch/load-store arbiter issuing single-beat 64-bit AXI4 transfers, one at a time.
// Optional watchdog: define DARKAXI_ARB_TIMEOUT_EN to abort stalled transfers after TIMEOUT_CYCLES.
module darkaxi_arb #(
  parameter logic [3:0] ID0            = 4'h0,
  parameter logic [3:0] ID1            = 4'h1,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [1:0]       req,
  input  logic [1:0]       we,
  input  logic [1:0][28:0] addr,
  input  logic [1:0][63:0] wdata,
  input  logic [1:0][7:0]  be,
  output logic [1:0]       ack,
  output logic             err,
  output logic [63:0]      rdata,
  output logic [1:0]       gnt,
  AXI_BUS.Master           axi
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

  state_t       state_q, state_d;
  logic         own_q, own_d;
  logic         last_q, last_d;
  logic         we_q, we_d;
  logic [28:3]  addr_q, addr_d;
  logic [63:0]  wdata_q, wdata_d;
  logic [7:0]   be_q, be_d;
  logic [3:0]   id_q, id_d;
  logic         arvalid_q, arvalid_d;
  logic         awvalid_q, awvalid_d;
  logic         wvalid_q, wvalid_d;
  logic         rready_q, rready_d;
  logic         bready_q, bready_d;
  logic [1:0]   ack_q, ack_d;
  logic         err_q, err_d;
  logic [63:0]  rdata_q, rdata_d;
  logic [1:0]   gnt_q, gnt_d;
  logic         win, aw_ok, w_ok;
`ifdef DARKAXI_ARB_TIMEOUT_EN
  logic [7:0]   cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    id_d      = id_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rready_d  = rready_q;
    bready_d  = bready_q;
    ack_d     = 2'b00;
    err_d     = err_q;
    rdata_d   = rdata_q;
    gnt_d     = gnt_q;
    win       = 1'b0;
    aw_ok     = 1'b0;
    w_ok      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          // Contention goes to whoever was not served last.
          win     = (req == 2'b11) ? ~last_q : req[1];
          own_d   = win;
          we_d    = we[win];
          addr_d  = addr[win][28:3];
          wdata_d = wdata[win];
          be_d    = be[win];
          id_d    = win ? ID1 : ID0;
          gnt_d   = win ? 2'b10 : 2'b01;
          if (we[win]) begin
            state_d   = WREQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      RADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (axi.rvalid) begin
          rready_d = 1'b0;
          rdata_d  = axi.rdata;
          err_d    = |axi.rresp;
          state_d  = DONE;
        end
      end
      WREQ: begin
        // A lowered valid marks that channel's handshake as already done.
        aw_ok = ~awvalid_q | axi.awready;
        w_ok  = ~wvalid_q | axi.wready;
        if (axi.awready) awvalid_d = 1'b0;
        if (axi.wready)  wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (axi.bvalid) begin
          bready_d = 1'b0;
          err_d    = |axi.bresp;
          state_d  = DONE;
        end
      end
      DONE: begin
        last_d  = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef DARKAXI_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    if (state_q inside {RADDR, RDATA, WREQ, WRESP}) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == TIMEOUT_CYCLES && state_d != DONE) begin
        arvalid_d = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        rready_d  = 1'b0;
        bready_d  = 1'b0;
        err_d     = 1'b1;
        rdata_d   = 64'hDEAD_DEAD_DEAD_DEAD;
        state_d   = DONE;
      end
    end
    if (state_q == IDLE || state_d == DONE) cnt_d = 8'd0;
`else
    // No watchdog: a stalled slave holds the arbiter indefinitely.
`endif

    if (state_q != DONE && state_d == DONE) begin
      ack_d = own_q ? 2'b10 : 2'b01;
      gnt_d = 2'b00;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q   <= IDLE;
      own_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      id_q      <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      ack_q     <= 2'b00;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      gnt_q     <= 2'b00;
`ifdef DARKAXI_ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      id_q      <= id_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rready_q  <= rready_d;
      bready_q  <= bready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      gnt_q     <= gnt_d;
`ifdef DARKAXI_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign gnt   = gnt_q;

  assign axi.awid    = id_q;
  assign axi.awaddr  = {addr_q, 3'b000};
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b011;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = 4'b0011;
  assign axi.awprot  = {~own_q, 2'b00};
  assign axi.awqos   = 4'd0;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.arid    = id_q;
  assign axi.araddr  = {addr_q, 3'b000};
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b011;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'b0011;
  assign axi.arprot  = {~own_q, 2'b00};
  assign axi.arqos   = 4'd0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

endmodule
